data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Data-memory controller directly downstream of the core's load/store port. It accepts one request at a time over the core's valid/yumi handshake and runs it against a byte-enabled on-chip SRAM after a programmable wait. It returns a registered response that is held until the core acknowledges it. Byte lanes, address range checks and a sticky error flag are handled here, so the core sees a plain word/byte memory.

## Interface
Parameters:
- addr_width_p, 10, word-address width; capacity is 2^addr_width_p 32-bit words
- latency_p, 1, extra wait cycles inserted before the SRAM access (0..7)

Ports:
- clk  in  1  clock
- n_reset  in  1  reset; the block uses a synchronous, active-low reset, n_reset, and clock clk
- to_mem_i  in  mem_in_s  request from core: write_data, valid, wen, byte_not_word, yumi (response ack)
- addr_i  in  32  byte address of the request, sampled with to_mem_i.valid
- from_mem_o  out  mem_out_s  response to core: read_data[31:0], valid, yumi (request ack)
- error_o  out  1  sticky access-error flag

## Operation
- FSM states are IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - from_mem_o.yumi = to_mem_i.valid, combinational.
  - On valid, the block registers addr_i, write_data, wen and byte_not_word.
  - Next state is WAIT if latency_p>0, else ACCESS.
- WAIT: a down-counter is loaded with latency_p-1 on accept. Move to ACCESS when it reaches 0.
- ACCESS: assert SRAM enable, then go to RESP.
  - Store: write the byte lanes selected by the captured address.
  - Load: read the word.
- RESP:
  - from_mem_o.valid=1.
  - When to_mem_i.yumi=1, return to IDLE.
  - from_mem_o.yumi=0; no new request is accepted in this cycle.
- Address decode:
  - word index = addr[2+:addr_width_p].
  - lane = addr[1:0].
  - The address is out of range if any bit of addr[31:addr_width_p+2] is set.
- Word op:
  - lane ignored (aligned access); lane!=0 sets error_o.
  - Store writes all 4 bytes; load returns the full word.
- Byte op:
  - Store writes byte `lane` with write_data[7:0].
  - Load returns the selected byte zero-extended to 32 bits.
- Out-of-range access:
  - Store is dropped (no SRAM write).
  - Load returns 0.
  - error_o is set.
  - The handshake completes normally.
- Store responses: read_data=0, but valid/yumi are still required.
- error_o is sticky and cleared only by reset.

## Timing
- Reset values:
  - State=IDLE, counter=0, error_o=0.
  - from_mem_o.valid=0 and from_mem_o.read_data=0.
  - from_mem_o.yumi=0 unless IDLE sees valid after reset.
  - SRAM contents are not cleared.
- Request accepted (yumi) in cycle 0.
  - ACCESS occurs in cycle 1+latency_p.
  - from_mem_o.valid rises in cycle 2+latency_p.
  - latency_p=0 gives valid at cycle 2.
- Response hold: valid and read_data stay constant every cycle until the cycle where to_mem_i.yumi=1 (inclusive). After that cycle, valid=0.
- Minimum spacing between accepts is 3+latency_p cycles.
- to_mem_i.valid outside IDLE is ignored.
- to_mem_i.yumi outside RESP is ignored.
- Reset asserted in any state:
  - The next cycle is IDLE with outputs at reset values.
  - An in-flight store reaching ACCESS in the reset cycle is not written.
- from_mem_o.valid and read_data are driven from registers/state only. from_mem_o.yumi is the only combinational output.

## Structure
- Package definitions holds the existing mem_in_s/mem_out_s types.
- It gains:
  - dmem_ctrl_state_e {DMC_IDLE, DMC_WAIT, DMC_ACCESS, DMC_RESP}.
  - Constant dmem_max_latency_gp=7.
- Sub-module dmem_sram (addr_width_p):
  - 4 byte-wide arrays, per-byte write enables.
  - Single port, registered 1-cycle read.
  - The controller captures its output into the response register in RESP entry.

## Test plan
- latency_p=0; word store 0xDEADBEEF to addr 0x10, then word load 0x10 -> yumi in cycle 0, valid in cycle 2, read_data 0xDEADBEEF, error_o=0.
- latency_p=3; load with core yumi delayed 4 cycles -> valid first in cycle 5, read_data stable 5 cycles, valid=0 the cycle after yumi.
- Byte stores 0x11,0x22,0x33,0x44 to 0x20..0x23 -> word load 0x20 returns 0x44332211; byte load 0x22 returns 0x00000033.
- Word load at 0x21 -> aligned word at 0x20 returned, error_o=1 and stays 1 through later good accesses.
- Store to address 1<<(addr_width_p+2) -> no SRAM change (reload word 0 unchanged), load from same address returns 0, error_o=1.
- Reset asserted during WAIT of a store with latency_p=3 -> next cycle IDLE, all outputs 0, target word unchanged; next request accepted immediately.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for the core's data-memory port and the controller state machine.
// The byte-enable helper keeps lane decoding identical wherever it is needed.
package data_mem_ctrl_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  typedef enum logic [1:0] {
    DMC_IDLE,
    DMC_WAIT,
    DMC_ACCESS,
    DMC_RESP
  } dmem_ctrl_state_e;

  localparam int dmem_max_latency_gp = 7;

  // Word ops touch every lane; byte ops touch only the addressed lane.
  function automatic logic [3:0] byte_enables(input logic byte_not_word, input logic [1:0] lane);
    return byte_not_word ? (4'b0001 << lane) : 4'b1111;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port byte-lane SRAM with per-byte write enables and a registered read.
// Read data reflects the contents before any same-cycle write.
module dmem_sram #(
  parameter int addr_width_p = 10
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [3:0]              we,
  input  logic [addr_width_p-1:0] addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] bank [2**addr_width_p];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we[i]) begin
          bank[addr] <= wdata[8*i +: 8];
        end
        q <= bank[addr];
      end
    end

    assign rdata[8*i +: 8] = q;
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: one request at a time over valid/yumi, programmable
// wait before the SRAM access, response held until the core acknowledges it.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  mem_in_s     to_mem_i,
  input  logic [31:0] addr_i,
  output mem_out_s    from_mem_o,
  output logic        error_o
);

  localparam int count_width = $clog2(dmem_max_latency_gp + 1);
  localparam logic [count_width-1:0] wait_load =
    (latency_p > 0) ? count_width'(latency_p - 1) : '0;

  dmem_ctrl_state_e state, state_next;

  logic [31:0]            addr_q;
  logic [31:0]            wdata_q;
  logic                   wen_q;
  logic                   bnw_q;
  logic [count_width-1:0] count;
  logic                   error_q;

  logic                    accept;
  logic                    sram_en;
  logic [3:0]              sram_we;
  logic [31:0]             sram_wdata;
  logic [31:0]             sram_rdata;
  logic [31:0]             load_data;
  logic [addr_width_p-1:0] word_index;
  logic [1:0]              lane;
  logic                    out_of_range;
  logic                    misaligned;

  assign word_index   = addr_q[2 +: addr_width_p];
  assign lane         = addr_q[1:0];
  assign out_of_range = |addr_q[31:addr_width_p+2];
  assign misaligned   = !bnw_q && (lane != 2'd0);

  // A synchronous reset must also suppress any accept or SRAM write in that cycle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    sram_en    = 1'b0;
    unique case (state)
      DMC_IDLE: begin
        if (to_mem_i.valid && n_reset) begin
          accept     = 1'b1;
          state_next = (latency_p > 0) ? DMC_WAIT : DMC_ACCESS;
        end
      end
      DMC_WAIT: begin
        if (count == '0) begin
          state_next = DMC_ACCESS;
        end
      end
      DMC_ACCESS: begin
        sram_en    = n_reset;
        state_next = DMC_RESP;
      end
      DMC_RESP: begin
        if (to_mem_i.yumi) begin
          state_next = DMC_IDLE;
        end
      end
      default: state_next = DMC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state   <= DMC_IDLE;
      count   <= '0;
      error_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        count <= wait_load;
      end else if (state == DMC_WAIT && count != '0) begin
        count <= count - 1'b1;
      end
      if (state == DMC_ACCESS && (out_of_range || misaligned)) begin
        error_q <= 1'b1;
      end
    end
  end

  // Request fields need no reset; they are only consumed after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= addr_i;
      wdata_q <= to_mem_i.write_data;
      wen_q   <= to_mem_i.wen;
      bnw_q   <= to_mem_i.byte_not_word;
    end
  end

  assign sram_we    = (sram_en && wen_q && !out_of_range) ? byte_enables(bnw_q, lane) : 4'b0000;
  assign sram_wdata = bnw_q ? {4{wdata_q[7:0]}} : wdata_q;

  dmem_sram #(
    .addr_width_p(addr_width_p)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (sram_we),
    .addr (word_index),
    .wdata(sram_wdata),
    .rdata(sram_rdata)
  );

  // The SRAM output register holds through RESP, so the response is stable until acked.
  always_comb begin
    load_data = '0;
    if (state == DMC_RESP && !wen_q && !out_of_range) begin
      load_data = bnw_q ? {24'b0, sram_rdata[{lane, 3'b000} +: 8]} : sram_rdata;
    end
  end

  always_comb begin
    from_mem_o           = '0;
    from_mem_o.read_data = load_data;
    from_mem_o.valid     = (state == DMC_RESP);
    from_mem_o.yumi      = accept;
  end

  assign error_o = error_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: two instances (latency 0 and 3) driven
// with directed and random requests against a byte-array reference model.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  localparam int aw   = 10;
  localparam int lat0 = 0;
  localparam int lat1 = 3;

  logic        clk = 1'b0;
  logic        n_reset;
  mem_in_s     to_mem   [2];
  logic [31:0] addr     [2];
  mem_out_s    from_mem [2];
  logic        error    [2];

  logic [7:0] model_mem [2][4*(2**aw)];
  bit         model_err [2];

  int checks   = 0;
  int failures = 0;

  data_mem_ctrl #(.addr_width_p(aw), .latency_p(lat0)) dut0 (
    .clk       (clk),
    .n_reset   (n_reset),
    .to_mem_i  (to_mem[0]),
    .addr_i    (addr[0]),
    .from_mem_o(from_mem[0]),
    .error_o   (error[0])
  );

  data_mem_ctrl #(.addr_width_p(aw), .latency_p(lat1)) dut1 (
    .clk       (clk),
    .n_reset   (n_reset),
    .to_mem_i  (to_mem[1]),
    .addr_i    (addr[1]),
    .from_mem_o(from_mem[1]),
    .error_o   (error[1])
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? lat0 : lat1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Applies the request to the model and returns the read data the core should see.
  function automatic logic [31:0] model_access(input int d, input bit wen, input bit bnw,
                                               input logic [31:0] a, input logic [31:0] wd);
    bit oor;
    int base;
    int lane;
    oor  = |a[31:aw+2];
    base = int'(a[aw+1:2]) * 4;
    lane = int'(a[1:0]);
    if (oor || (!bnw && lane != 0)) model_err[d] = 1'b1;
    if (wen) begin
      if (!oor) begin
        if (bnw) model_mem[d][base+lane] = wd[7:0];
        else for (int i = 0; i < 4; i++) model_mem[d][base+i] = wd[8*i +: 8];
      end
      return 32'h0;
    end
    if (oor) return 32'h0;
    if (bnw) return {24'h0, model_mem[d][base+lane]};
    return {model_mem[d][base+3], model_mem[d][base+2], model_mem[d][base+1], model_mem[d][base]};
  endfunction

  task automatic apply_stimulus(input int d, input bit wen, input bit bnw, input logic [31:0] a,
                                input logic [31:0] wd, input int yumi_delay);
    logic [31:0] expected;
    int          c;
    bit          seen;
    expected = model_access(d, wen, bnw, a, wd);
    @(posedge clk); #1;
    to_mem[d].valid         = 1'b1;
    to_mem[d].wen           = wen;
    to_mem[d].byte_not_word = bnw;
    to_mem[d].write_data    = wd;
    addr[d]                 = a;
    @(negedge clk);
    check_output($sformatf("d%0d accept yumi @%h", d, a), from_mem[d].yumi, 1);
    @(posedge clk); #1;
    to_mem[d].valid = 1'b0;
    c    = 1;
    seen = 1'b0;
    while (c < 20 && !seen) begin
      @(negedge clk);
      if (from_mem[d].valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        c++;
      end
    end
    check_output($sformatf("d%0d valid latency @%h", d, a), c, 2 + lat_of(d));
    for (int k = 0; k <= yumi_delay; k++) begin
      if (k > 0) @(negedge clk);
      check_output($sformatf("d%0d resp valid k%0d", d, k), from_mem[d].valid, 1);
      check_output($sformatf("d%0d read_data @%h k%0d", d, a, k), from_mem[d].read_data, expected);
      check_output($sformatf("d%0d busy yumi k%0d", d, k), from_mem[d].yumi, 0);
      if (k == yumi_delay) to_mem[d].yumi = 1'b1;
      @(posedge clk); #1;
      to_mem[d].yumi = 1'b0;
    end
    @(negedge clk);
    check_output($sformatf("d%0d valid after ack", d), from_mem[d].valid, 0);
    check_output($sformatf("d%0d error_o", d), error[d], model_err[d]);
  endtask

  // Store to word 5 of dut1, with reset pulsed k cycles after the accept cycle.
  task automatic reset_during(input int k, input logic [31:0] wd);
    @(posedge clk); #1;
    to_mem[1].valid         = 1'b1;
    to_mem[1].wen           = 1'b1;
    to_mem[1].byte_not_word = 1'b0;
    to_mem[1].write_data    = wd;
    addr[1]                 = 32'h14;
    @(negedge clk);
    check_output("reset test accept", from_mem[1].yumi, 1);
    @(posedge clk); #1;
    to_mem[1].valid = 1'b0;
    repeat (k - 1) @(posedge clk);
    #1 n_reset = 1'b0;
    @(posedge clk); #1;
    n_reset = 1'b1;
    model_err[0] = 1'b0;
    model_err[1] = 1'b0;
    @(negedge clk);
    check_output($sformatf("reset k%0d valid", k), from_mem[1].valid, 0);
    check_output($sformatf("reset k%0d read_data", k), from_mem[1].read_data, 0);
    check_output($sformatf("reset k%0d yumi", k), from_mem[1].yumi, 0);
    check_output($sformatf("reset k%0d error1", k), error[1], 0);
    check_output($sformatf("reset k%0d error0", k), error[0], 0);
    apply_stimulus(1, 1'b0, 1'b0, 32'h14, 32'h0, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          d;
    for (int i = 0; i < 2; i++) begin
      to_mem[i] = '0;
      addr[i]   = '0;
    end
    n_reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("d%0d reset valid", i), from_mem[i].valid, 0);
      check_output($sformatf("d%0d reset read_data", i), from_mem[i].read_data, 0);
      check_output($sformatf("d%0d reset yumi", i), from_mem[i].yumi, 0);
      check_output($sformatf("d%0d reset error", i), error[i], 0);
    end
    @(posedge clk); #1;
    n_reset = 1'b1;

    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 16; w++)
        apply_stimulus(i, 1'b1, 1'b0, 32'(w * 4), $urandom, 0);

    apply_stimulus(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    apply_stimulus(0, 1'b0, 1'b0, 32'h10, 32'h0, 0);
    check_output("deadbeef model", model_access(0, 1'b0, 1'b0, 32'h10, 32'h0), 32'hDEADBEEF);

    apply_stimulus(1, 1'b0, 1'b0, 32'hC, 32'h0, 4);

    for (int i = 0; i < 4; i++)
      apply_stimulus(0, 1'b1, 1'b1, 32'(32'h20 + i), {24'hA5A5A5, 8'(8'h11 * (i + 1))}, 1);
    apply_stimulus(0, 1'b0, 1'b0, 32'h20, 32'h0, 0);
    apply_stimulus(0, 1'b0, 1'b1, 32'h22, 32'h0, 2);
    check_output("byte lanes model", model_access(0, 1'b0, 1'b0, 32'h20, 32'h0), 32'h44332211);

    apply_stimulus(0, 1'b0, 1'b0, 32'h21, 32'h0, 0);
    apply_stimulus(0, 1'b0, 1'b0, 32'h10, 32'h0, 0);

    apply_stimulus(0, 1'b1, 1'b0, 32'h1 << (aw + 2), 32'hCAFEF00D, 0);
    apply_stimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 0);
    apply_stimulus(0, 1'b0, 1'b0, 32'h1 << (aw + 2), 32'h0, 0);

    for (int n = 0; n < 120; n++) begin
      d = int'($urandom_range(1, 0));
      a = 32'($urandom_range(63, 0));
      if ($urandom_range(7, 0) == 0) a = a | (32'h1 << $urandom_range(31, aw + 2));
      apply_stimulus(d, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), a, $urandom,
                     int'($urandom_range(3, 0)));
    end

    reset_during(2, 32'h0BADF00D);
    reset_during(4, 32'h12345678);
    apply_stimulus(1, 1'b0, 1'b1, 32'h15, 32'h0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
